ce_strobe_gen: RTL and testbench
================================

CE_STROBE_GEN -- requirements
Module: ce_strobe_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the period divider.
REQ-002 SHALL have parameter CNT_W, default 8, width of the burst pulse counter.
REQ-003 SHALL have port CK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  single-cycle request to begin a strobe burst.
REQ-006 SHALL have port ABORT  input  1  terminates any burst.
REQ-007 SHALL have port DIV  input  DIV_W  strobe period minus one, in CK cycles.
REQ-008 SHALL have port NPULSE  input  CNT_W  strobes per burst; 0 means continuous.
REQ-009 SHALL have port DIN  input  1  data to hand to the downstream enable-flop.
REQ-010 SHALL have port SP  output  1  registered clock-enable strobe for the downstream flop SP pin.
REQ-011 SHALL have port D  output  1  registered data, updated only on strobe cycles.
REQ-012 SHALL have port BUSY  output  1  high while a burst is running.
REQ-013 SHALL have port DONE  output  1  single-cycle pulse on normal burst completion.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FINISH.
REQ-015 SHALL, in IDLE with START=1 and ABORT=0, capture DIV and NPULSE into shadow registers, load the period counter with DIV and enter RUN.
REQ-016 SHALL ignore DIV and NPULSE changes while in RUN or FINISH.
REQ-017 SHALL ignore START while in RUN or FINISH.
REQ-018 SHALL, in RUN, decrement the period counter each cycle, and when it is 0 assert SP for exactly one cycle and reload it with shadow DIV.
REQ-019 SHALL place the first SP DIV+1 cycles after the edge that sampled START, with spacing DIV+1 cycles thereafter.
REQ-020 SHALL give continuous SP=1 in RUN when DIV=0.
REQ-021 SHALL load D from DIN on the same edge that sets SP=1, and hold D otherwise.
REQ-022 SHALL count issued strobes and, when NPULSE is nonzero and the count reaches NPULSE, enter FINISH on the edge that issues the last SP.
REQ-023 SHALL let the pulse counter free-run modulo 2^CNT_W without terminating when NPULSE=0.
REQ-024 SHALL assert DONE=1 for the single FINISH cycle, then return to IDLE.
REQ-025 SHALL drive BUSY=1 in RUN and FINISH, and BUSY=0 in IDLE.
REQ-026 SHALL, on ABORT=1 in any state, enter IDLE at the next edge with SP=0, DONE=0 and D held.
REQ-027 SHALL give ABORT priority when START and ABORT are high together.

Reset
REQ-028 SHALL, with RSTN=0, immediately force state IDLE, SP=0, D=1, BUSY=0, DONE=0, and all counters and shadows to 0, independent of CK.
REQ-029 SHALL, on reset mid-burst, drop any pending strobe and not assert DONE.
REQ-030 SHALL release reset on the first CK edge with RSTN=1, with the module accepting START on that edge.

Structure
REQ-031 SHALL place the state enum (IDLE, RUN, FINISH) and default widths in package ce_strobe_pkg.
REQ-032 SHALL implement the loadable down-counter as sub-module ce_div_counter, instantiated once for the period.

Verification
REQ-033 SHALL cover this case: DIV=3, NPULSE=4, START at cycle 0 -> SP high at cycles 4,8,12,16; DONE at 17; BUSY 1..17.
REQ-034 SHALL cover this case: DIV=0, NPULSE=3, DIN=0,1,0 on strobes -> SP high cycles 1-3; D follows 0,1,0; DONE at cycle 4.
REQ-035 SHALL cover this case: NPULSE=0, DIV=1, ABORT at cycle 9 -> SP at 2,4,6,8; none after; DONE never; BUSY 0 at 10.
REQ-036 SHALL cover this case: START and ABORT both high in IDLE -> remains IDLE, BUSY=0, no SP.
REQ-037 SHALL cover this case: RSTN low mid-burst between edges -> SP=0, D=1, BUSY=0 immediately; no DONE after release.
REQ-038 SHALL cover this case: DIV changed 3->7 during RUN -> spacing stays 4 until burst end; next START uses 8.

Source files
------------

// File: rtl/ce_strobe_pkg.sv
// Shared types and default widths for the clock-enable strobe generator.
// No logic; compile before any file that imports it.
// Not applicable (no datapath).
package ce_strobe_pkg;

    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/ce_div_counter.sv
// Loadable down-counter that sets the strobe period; load wins over decrement.
// Latency: the new count is visible one cycle after load/dec.
// No backpressure; the parent drives load/dec every cycle.
module ce_div_counter #(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count register: reload takes priority, otherwise step down by one.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ce_strobe_gen.sv
// Burst generator of clock-enable strobes (SP) plus gated data (D) for a downstream enable-flop.
// Latency: first SP DIV+1 cycles after the START edge; BUSY/DONE lag the state by one cycle.
// No backpressure: START is ignored while busy, ABORT always wins.
module ce_strobe_gen
    import ce_strobe_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             ABORT,
    input  logic [DIV_W-1:0] DIV,
    input  logic [CNT_W-1:0] NPULSE,
    input  logic             DIN,
    output logic             SP,
    output logic             D,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_sh;
    logic [CNT_W-1:0] npulse_sh;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] pcnt_inc;
    logic             start_acc;
    logic             strobe;
    logic             last;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic [DIV_W-1:0] cnt_load_val;
    logic             sp_r;
    logic             d_r;
    logic             busy_r;
    logic             done_r;

    assign pcnt_inc = pcnt + 1'b1;

    // The period counter is reloaded on a fresh start (live DIV) or after each strobe (shadow DIV).
    assign cnt_load     = start_acc | strobe;
    assign cnt_load_val = start_acc ? DIV : div_sh;
    assign cnt_dec      = (state == RUN) && !cnt_zero;

    ce_div_counter #(
        .W (DIV_W)
    ) u_period (
        .ck       (CK),
        .rst_n    (RSTN),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; ABORT overrides everything, including a simultaneous START.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        strobe    = 1'b0;
        last      = 1'b0;
        if (ABORT) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        start_acc = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (cnt_zero) begin
                        strobe = 1'b1;
                        // NPULSE of zero means run forever; the counter just wraps.
                        last   = (npulse_sh != '0) && (pcnt_inc == npulse_sh);
                        if (last) begin
                            state_nxt = FINISH;
                        end
                    end
                end
                FINISH: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Shadow copies of the burst setup and the issued-strobe count.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            div_sh    <= '0;
            npulse_sh <= '0;
            pcnt      <= '0;
        end else if (start_acc) begin
            div_sh    <= DIV;
            npulse_sh <= NPULSE;
            pcnt      <= '0;
        end else if (strobe) begin
            pcnt      <= pcnt_inc;
        end
    end

    // Registered outputs; D only moves on a strobe edge so it lines up with SP downstream.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            sp_r   <= 1'b0;
            d_r    <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            sp_r   <= strobe;
            busy_r <= !ABORT && (state != IDLE);
            done_r <= !ABORT && (state == FINISH);
            if (strobe) begin
                d_r <= DIN;
            end
        end
    end

    assign SP   = sp_r;
    assign D    = d_r;
    assign BUSY = busy_r;
    assign DONE = done_r;

endmodule

// File: tb/tb_ce_strobe_gen.sv
module tb_ce_strobe_gen;

    logic       CK = 1'b0;
    logic       RSTN;
    logic       START;
    logic       ABORT;
    logic [7:0] DIV;
    logic [7:0] NPULSE;
    logic       DIN;
    logic       SP;
    logic       D;
    logic       BUSY;
    logic       DONE;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_d;
    logic exp_sp;
    logic exp_busy;
    logic exp_done;

    always #5 CK = ~CK;

    ce_strobe_gen #(
        .DIV_W (8),
        .CNT_W (8)
    ) dut (
        .CK     (CK),
        .RSTN   (RSTN),
        .START  (START),
        .ABORT  (ABORT),
        .DIV    (DIV),
        .NPULSE (NPULSE),
        .DIN    (DIN),
        .SP     (SP),
        .D      (D),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    // Cycle k = values sampled 1 time unit after rising edge k.
    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic test_reset;
        RSTN = 1'b0; START = 1'b1; ABORT = 1'b0; DIN = 1'b0; DIV = 8'd0; NPULSE = 8'd0;
        exp_d = 1'b1;
        #12;
        n_cmp++; if (SP !== 1'b0)   begin n_err++; $display("FAIL reset_sp: got %b want 0", SP); end
        n_cmp++; if (D !== 1'b1)    begin n_err++; $display("FAIL reset_d: got %b want 1", D); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", DONE); end
        START = 1'b0;
        RSTN  = 1'b1;
    endtask

    // DIV=3, NPULSE=4: SP at 4,8,12,16, DONE at 17, BUSY 1..17; a START mid-burst is ignored.
    task automatic test_basic;
        DIV = 8'd3; NPULSE = 8'd4; DIN = 1'b0; START = 1'b1;
        tick;
        START = 1'b0;
        n_cmp++; if (SP !== 1'b0)   begin n_err++; $display("FAIL basic_sp cyc0: got %b want 0", SP); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL basic_busy cyc0: got %b want 0", BUSY); end
        for (int c = 1; c <= 19; c++) begin
            DIN   = (c % 3 == 1);
            START = (c == 6);
            tick;
            exp_sp   = (c % 4 == 0) && (c <= 16);
            exp_busy = (c <= 17);
            exp_done = (c == 17);
            if (exp_sp) exp_d = DIN;
            n_cmp++; if (SP !== exp_sp)     begin n_err++; $display("FAIL basic_sp cyc%0d: got %b want %b", c, SP, exp_sp); end
            n_cmp++; if (D !== exp_d)       begin n_err++; $display("FAIL basic_d cyc%0d: got %b want %b", c, D, exp_d); end
            n_cmp++; if (BUSY !== exp_busy) begin n_err++; $display("FAIL basic_busy cyc%0d: got %b want %b", c, BUSY, exp_busy); end
            n_cmp++; if (DONE !== exp_done) begin n_err++; $display("FAIL basic_done cyc%0d: got %b want %b", c, DONE, exp_done); end
        end
        START = 1'b0;
    endtask

    // DIV=0, NPULSE=3: SP 1..3 with D = 0,1,0, DONE at 4; D holds while DIN keeps moving.
    task automatic test_div0;
        DIV = 8'd0; NPULSE = 8'd3; DIN = 1'b1; START = 1'b1;
        tick;
        START = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            DIN = (c == 2) || (c >= 4);
            tick;
            exp_sp   = (c <= 3);
            exp_busy = (c <= 4);
            exp_done = (c == 4);
            if (exp_sp) exp_d = DIN;
            n_cmp++; if (SP !== exp_sp)     begin n_err++; $display("FAIL div0_sp cyc%0d: got %b want %b", c, SP, exp_sp); end
            n_cmp++; if (D !== exp_d)       begin n_err++; $display("FAIL div0_d cyc%0d: got %b want %b", c, D, exp_d); end
            n_cmp++; if (BUSY !== exp_busy) begin n_err++; $display("FAIL div0_busy cyc%0d: got %b want %b", c, BUSY, exp_busy); end
            n_cmp++; if (DONE !== exp_done) begin n_err++; $display("FAIL div0_done cyc%0d: got %b want %b", c, DONE, exp_done); end
        end
    endtask

    // NPULSE=0 (continuous), DIV=1, ABORT during cycle 9: SP 2,4,6,8, BUSY low from 10, no DONE.
    task automatic test_abort;
        DIV = 8'd1; NPULSE = 8'd0; START = 1'b1;
        tick;
        START = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            ABORT = (c == 10);
            DIN   = (c % 4 == 2);
            tick;
            exp_sp   = (c % 2 == 0) && (c < 10);
            exp_busy = (c <= 9);
            exp_done = 1'b0;
            if (exp_sp) exp_d = DIN;
            n_cmp++; if (SP !== exp_sp)     begin n_err++; $display("FAIL abort_sp cyc%0d: got %b want %b", c, SP, exp_sp); end
            n_cmp++; if (D !== exp_d)       begin n_err++; $display("FAIL abort_d cyc%0d: got %b want %b", c, D, exp_d); end
            n_cmp++; if (BUSY !== exp_busy) begin n_err++; $display("FAIL abort_busy cyc%0d: got %b want %b", c, BUSY, exp_busy); end
            n_cmp++; if (DONE !== exp_done) begin n_err++; $display("FAIL abort_done cyc%0d: got %b want %b", c, DONE, exp_done); end
        end
        ABORT = 1'b0;
    endtask

    // START and ABORT together in IDLE: nothing starts.
    task automatic test_start_abort;
        DIV = 8'd0; NPULSE = 8'd1; START = 1'b1; ABORT = 1'b1;
        tick;
        START = 1'b0; ABORT = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick;
            n_cmp++; if (SP !== 1'b0)   begin n_err++; $display("FAIL stab_sp cyc%0d: got %b want 0", c, SP); end
            n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL stab_busy cyc%0d: got %b want 0", c, BUSY); end
            n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL stab_done cyc%0d: got %b want 0", c, DONE); end
        end
    endtask

    // DIV 3->7 mid-burst keeps spacing 4 (SP 4,8,12, DONE 13); the next burst uses 8.
    task automatic test_div_change;
        DIV = 8'd3; NPULSE = 8'd3; DIN = 1'b1; START = 1'b1;
        tick;
        START = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) begin DIV = 8'd7; NPULSE = 8'd1; end
            tick;
            exp_sp   = (c % 4 == 0) && (c <= 12);
            exp_busy = (c <= 13);
            exp_done = (c == 13);
            if (exp_sp) exp_d = DIN;
            n_cmp++; if (SP !== exp_sp)     begin n_err++; $display("FAIL dchg_sp cyc%0d: got %b want %b", c, SP, exp_sp); end
            n_cmp++; if (D !== exp_d)       begin n_err++; $display("FAIL dchg_d cyc%0d: got %b want %b", c, D, exp_d); end
            n_cmp++; if (BUSY !== exp_busy) begin n_err++; $display("FAIL dchg_busy cyc%0d: got %b want %b", c, BUSY, exp_busy); end
            n_cmp++; if (DONE !== exp_done) begin n_err++; $display("FAIL dchg_done cyc%0d: got %b want %b", c, DONE, exp_done); end
        end
        START = 1'b1;
        tick;
        START = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            DIN = 1'b0;
            tick;
            exp_sp   = (c == 8);
            exp_busy = (c <= 9);
            exp_done = (c == 9);
            if (exp_sp) exp_d = DIN;
            n_cmp++; if (SP !== exp_sp)     begin n_err++; $display("FAIL dchg2_sp cyc%0d: got %b want %b", c, SP, exp_sp); end
            n_cmp++; if (D !== exp_d)       begin n_err++; $display("FAIL dchg2_d cyc%0d: got %b want %b", c, D, exp_d); end
            n_cmp++; if (BUSY !== exp_busy) begin n_err++; $display("FAIL dchg2_busy cyc%0d: got %b want %b", c, BUSY, exp_busy); end
            n_cmp++; if (DONE !== exp_done) begin n_err++; $display("FAIL dchg2_done cyc%0d: got %b want %b", c, DONE, exp_done); end
        end
    endtask

    // Reset asserted between edges mid-burst acts at once; START on the release edge is accepted.
    task automatic test_reset_mid;
        DIV = 8'd2; NPULSE = 8'd5; DIN = 1'b0; START = 1'b1;
        tick;
        START = 1'b0;
        for (int c = 1; c <= 3; c++) tick;
        exp_d = 1'b0;
        n_cmp++; if (SP !== 1'b1) begin n_err++; $display("FAIL rmid_sp_pre: got %b want 1", SP); end
        n_cmp++; if (D !== exp_d) begin n_err++; $display("FAIL rmid_d_pre: got %b want %b", D, exp_d); end
        #2 RSTN = 1'b0;
        #1;
        exp_d = 1'b1;
        n_cmp++; if (SP !== 1'b0)   begin n_err++; $display("FAIL rmid_sp: got %b want 0", SP); end
        n_cmp++; if (D !== exp_d)   begin n_err++; $display("FAIL rmid_d: got %b want 1", D); end
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %b want 0", DONE); end
        tick;
        RSTN = 1'b1; START = 1'b1; DIV = 8'd1; NPULSE = 8'd2; DIN = 1'b0;
        tick;
        START = 1'b0;
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rel_busy cyc0: got %b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL rel_done cyc0: got %b want 0", DONE); end
        for (int c = 1; c <= 7; c++) begin
            tick;
            exp_sp   = (c == 2) || (c == 4);
            exp_busy = (c <= 5);
            exp_done = (c == 5);
            if (exp_sp) exp_d = DIN;
            n_cmp++; if (SP !== exp_sp)     begin n_err++; $display("FAIL rel_sp cyc%0d: got %b want %b", c, SP, exp_sp); end
            n_cmp++; if (D !== exp_d)       begin n_err++; $display("FAIL rel_d cyc%0d: got %b want %b", c, D, exp_d); end
            n_cmp++; if (BUSY !== exp_busy) begin n_err++; $display("FAIL rel_busy cyc%0d: got %b want %b", c, BUSY, exp_busy); end
            n_cmp++; if (DONE !== exp_done) begin n_err++; $display("FAIL rel_done cyc%0d: got %b want %b", c, DONE, exp_done); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div0;
        test_abort;
        test_start_abort;
        test_div_change;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
